// File: rtl/ddr_timing_pkg.sv
// Shared encodings for the multi-bank DDR timing tracker: command codes, bank state codes
// and a saturating counter helper used by the optional DDR_CMD_STATS_EN statistics.
package ddr_timing_pkg;

  localparam int STATE_W = 3;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ACT = 4'd1;
  localparam logic [3:0] CMD_RD  = 4'd2;
  localparam logic [3:0] CMD_RDA = 4'd3;
  localparam logic [3:0] CMD_WR  = 4'd4;
  localparam logic [3:0] CMD_WRA = 4'd5;
  localparam logic [3:0] CMD_PR  = 4'd6;
  localparam logic [3:0] CMD_PRA = 4'd7;
  localparam logic [3:0] CMD_REF = 4'd8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE        = 3'd0,
    ST_ACTIVATING  = 3'd1,
    ST_ACTIVE      = 3'd2,
    ST_READING     = 3'd3,
    ST_WRITING     = 3'd4,
    ST_PRECHARGING = 3'd5,
    ST_REFRESHING  = 3'd6
  } bank_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ddr_bank_fsm.sv
// One DDR bank: state machine plus down-counter that holds each timed state for exactly
// its programmed number of unhalted cycles. Strobes arrive already checked for legality.
module ddr_bank_fsm
  import ddr_timing_pkg::*;
#(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          halt,
  input  logic          go_act,
  input  logic          go_rd,
  input  logic          go_wr,
  input  logic          go_ap,
  input  logic          go_pr,
  input  logic          go_ref,
  input  logic [TW-1:0] t_rcd,
  input  logic [TW-1:0] t_rp,
  input  logic [TW-1:0] t_cl,
  input  logic [TW-1:0] t_bl,
  input  logic [TW-1:0] t_wr,
  input  logic [TW-1:0] t_rfc,
  output bank_state_t   state,
  output logic          in_data_window
);

  // One extra bit so that T_CL+T_BL and T_BL+T_WR cannot overflow
  localparam int CW = TW + 1;
  localparam logic [CW-1:0] ONE = CW'(1);

  bank_state_t   state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          ap_r, ap_s;
  logic          cnt_zero_s;

  assign cnt_zero_s = (cnt_r == {CW{1'b0}});

  // State, counter and auto-precharge flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
      ap_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      ap_r    <= ap_s;
    end
  end

  // Next-state and counter reload/decrement; everything holds while halted
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    ap_s    = ap_r;
    if (halt) begin
      state_s = state_r;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (go_act) begin
            state_s = ST_ACTIVATING;
            cnt_s   = {1'b0, t_rcd} - ONE;
          end else if (go_ref) begin
            state_s = ST_REFRESHING;
            cnt_s   = {1'b0, t_rfc} - ONE;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_ACTIVATING: begin
          if (cnt_zero_s) begin
            state_s = ST_ACTIVE;
          end else begin
            cnt_s = cnt_r - ONE;
          end
        end
        ST_ACTIVE: begin
          if (go_rd) begin
            state_s = ST_READING;
            cnt_s   = {1'b0, t_cl} + {1'b0, t_bl} - ONE;
            ap_s    = go_ap;
          end else if (go_wr) begin
            state_s = ST_WRITING;
            cnt_s   = {1'b0, t_bl} + {1'b0, t_wr} - ONE;
            ap_s    = go_ap;
          end else if (go_pr) begin
            state_s = ST_PRECHARGING;
            cnt_s   = {1'b0, t_rp} - ONE;
          end else begin
            state_s = ST_ACTIVE;
          end
        end
        ST_READING, ST_WRITING: begin
          if (cnt_zero_s) begin
            ap_s = 1'b0;
            if (ap_r) begin
              state_s = ST_PRECHARGING;
              cnt_s   = {1'b0, t_rp} - ONE;
            end else begin
              state_s = ST_ACTIVE;
            end
          end else begin
            cnt_s = cnt_r - ONE;
          end
        end
        ST_PRECHARGING, ST_REFRESHING: begin
          if (cnt_zero_s) begin
            state_s = ST_IDLE;
          end else begin
            cnt_s = cnt_r - ONE;
          end
        end
        default: begin
          state_s = ST_IDLE;
          cnt_s   = {CW{1'b0}};
          ap_s    = 1'b0;
        end
      endcase
    end
  end

  assign state          = state_r;
  assign in_data_window = (state_r == ST_READING) && (cnt_r < {1'b0, t_bl});

endmodule

// File: rtl/ddr_multibank_timing.sv
// NBANKS-bank DDR timing tracker: command decode, global legality, read-data flag and error pulse.
// Optional per-class command counters are built when DDR_CMD_STATS_EN is defined.
module ddr_multibank_timing
  import ddr_timing_pkg::*;
#(
  parameter int NBANKS = 4,
  parameter int BA_W   = $clog2(NBANKS),
  parameter int TW     = 8,
  parameter int T_RCD  = 3,
  parameter int T_RP   = 3,
  parameter int T_CL   = 4,
  parameter int T_BL   = 4,
  parameter int T_WR   = 2,
  parameter int T_RFC  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        halt,
  input  logic                        cmd_valid,
  input  logic [3:0]                  cmd,
  input  logic [BA_W-1:0]             cmd_bank,
  output logic                        cmd_ready,
  output logic                        cmd_err,
  output logic                        rd_valid,
  output logic [BA_W-1:0]             rd_bank,
  output logic [STATE_W*NBANKS-1:0]   bank_state,
  output logic [NBANKS-1:0]           bank_open
`ifdef DDR_CMD_STATS_EN
  ,
  output logic [31:0]                 stat_act,
  output logic [31:0]                 stat_rd,
  output logic [31:0]                 stat_wr,
  output logic [31:0]                 stat_pr,
  output logic [31:0]                 stat_ref,
  output logic [31:0]                 stat_err
`endif
);

  bank_state_t       st_s [NBANKS];
  bank_state_t       tgt_s;
  logic [NBANKS-1:0] win_s, go_act_s, go_rd_s, go_wr_s, go_pr_s, go_ref_s;
  logic              go_ap_s, acc_s, legal_s, do_s;
  logic              bus_busy_s, pra_block_s, all_idle_s;
  logic [BA_W-1:0]   win_bank_s;

  assign cmd_ready = ~halt;
  assign acc_s     = cmd_valid & ~halt;
  assign do_s      = acc_s & legal_s;
  assign tgt_s     = st_s[cmd_bank];
  assign go_ap_s   = (cmd == CMD_RDA) | (cmd == CMD_WRA);

  // Bank-wide status; at most one bank can be in its data window, so OR-ing indices is exact
  always_comb begin
    bus_busy_s  = 1'b0;
    pra_block_s = 1'b0;
    all_idle_s  = 1'b1;
    win_bank_s  = {BA_W{1'b0}};
    for (int b = 0; b < NBANKS; b++) begin
      bus_busy_s  = bus_busy_s | (st_s[b] == ST_READING) | (st_s[b] == ST_WRITING);
      pra_block_s = pra_block_s | (st_s[b] == ST_ACTIVATING) | (st_s[b] == ST_READING)
                    | (st_s[b] == ST_WRITING);
      all_idle_s  = all_idle_s & (st_s[b] == ST_IDLE);
      win_bank_s  = win_bank_s | (win_s[b] ? BA_W'(b) : {BA_W{1'b0}});
    end
  end

  // Legality judged on the pre-edge bank states
  always_comb begin
    legal_s = 1'b0;
    case (cmd)
      CMD_NOP:                          legal_s = 1'b1;
      CMD_ACT:                          legal_s = (tgt_s == ST_IDLE);
      CMD_RD, CMD_RDA, CMD_WR, CMD_WRA: legal_s = (tgt_s == ST_ACTIVE) & ~bus_busy_s;
      CMD_PR:                           legal_s = (tgt_s == ST_ACTIVE) | (tgt_s == ST_IDLE);
      CMD_PRA:                          legal_s = ~pra_block_s;
      CMD_REF:                          legal_s = all_idle_s;
      default:                          legal_s = 1'b0;
    endcase
  end

  // Per-bank strobes; PRA and REF fan out to every bank, which ignores them when not applicable
  always_comb begin
    go_act_s = {NBANKS{1'b0}};
    go_rd_s  = {NBANKS{1'b0}};
    go_wr_s  = {NBANKS{1'b0}};
    go_pr_s  = {NBANKS{1'b0}};
    go_ref_s = {NBANKS{1'b0}};
    for (int b = 0; b < NBANKS; b++) begin
      go_act_s[b] = do_s & (cmd == CMD_ACT) & (cmd_bank == BA_W'(b));
      go_rd_s[b]  = do_s & ((cmd == CMD_RD) | (cmd == CMD_RDA)) & (cmd_bank == BA_W'(b));
      go_wr_s[b]  = do_s & ((cmd == CMD_WR) | (cmd == CMD_WRA)) & (cmd_bank == BA_W'(b));
      go_pr_s[b]  = do_s & (((cmd == CMD_PR) & (cmd_bank == BA_W'(b))) | (cmd == CMD_PRA));
      go_ref_s[b] = do_s & (cmd == CMD_REF);
    end
  end

  for (genvar g = 0; g < NBANKS; g++) begin : g_bank
    ddr_bank_fsm #(.TW(TW)) u_bank (
      .clk            (clk),
      .rst            (rst),
      .halt           (halt),
      .go_act         (go_act_s[g]),
      .go_rd          (go_rd_s[g]),
      .go_wr          (go_wr_s[g]),
      .go_ap          (go_ap_s),
      .go_pr          (go_pr_s[g]),
      .go_ref         (go_ref_s[g]),
      .t_rcd          (TW'(T_RCD)),
      .t_rp           (TW'(T_RP)),
      .t_cl           (TW'(T_CL)),
      .t_bl           (TW'(T_BL)),
      .t_wr           (TW'(T_WR)),
      .t_rfc          (TW'(T_RFC)),
      .state          (st_s[g]),
      .in_data_window (win_s[g])
    );
    assign bank_state[g*STATE_W +: STATE_W] = st_s[g];
    assign bank_open[g] = (st_s[g] == ST_ACTIVE) | (st_s[g] == ST_READING)
                          | (st_s[g] == ST_WRITING);
  end

  // Registered error pulse and read-data flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_err  <= 1'b0;
      rd_valid <= 1'b0;
      rd_bank  <= {BA_W{1'b0}};
    end else begin
      cmd_err <= acc_s & ~legal_s;
      if (!halt) begin
        rd_valid <= |win_s;
        rd_bank  <= win_bank_s;
      end
    end
  end

`ifdef DDR_CMD_STATS_EN
  // Saturating command statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_act <= 32'd0;
      stat_rd  <= 32'd0;
      stat_wr  <= 32'd0;
      stat_pr  <= 32'd0;
      stat_ref <= 32'd0;
      stat_err <= 32'd0;
    end else begin
      if (acc_s & ~legal_s) stat_err <= sat_inc(stat_err);
      if (do_s) begin
        case (cmd)
          CMD_ACT:          stat_act <= sat_inc(stat_act);
          CMD_RD, CMD_RDA:  stat_rd  <= sat_inc(stat_rd);
          CMD_WR, CMD_WRA:  stat_wr  <= sat_inc(stat_wr);
          CMD_PR, CMD_PRA:  stat_pr  <= sat_inc(stat_pr);
          CMD_REF:          stat_ref <= sat_inc(stat_ref);
          default:          stat_err <= stat_err;
        endcase
      end
    end
  end
`endif

endmodule

// File: tb/tb_ddr_multibank_timing.sv
// Self-checking bench for ddr_multibank_timing: directed vector table, halt/reset sequences,
// and random traffic against a time-stamp based reference model.
module tb_ddr_multibank_timing;
  import ddr_timing_pkg::*;

  localparam int NB = 4;
  localparam int T_RCD = 3, T_RP = 3, T_CL = 4, T_BL = 4, T_WR = 2, T_RFC = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halt = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [3:0]  cmd = 4'd0;
  logic [1:0]  cmd_bank = 2'd0;
  logic        cmd_ready, cmd_err, rd_valid;
  logic [1:0]  rd_bank;
  logic [11:0] bank_state;
  logic [3:0]  bank_open;
`ifdef DDR_CMD_STATS_EN
  logic [31:0] stat_act, stat_rd, stat_wr, stat_pr, stat_ref, stat_err;
`endif

  always #5 clk = ~clk;

  ddr_multibank_timing #(.NBANKS(NB), .TW(8), .T_RCD(T_RCD), .T_RP(T_RP), .T_CL(T_CL),
                         .T_BL(T_BL), .T_WR(T_WR), .T_RFC(T_RFC)) dut (
    .clk(clk), .rst(rst), .halt(halt), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_bank(cmd_bank),
    .cmd_ready(cmd_ready), .cmd_err(cmd_err), .rd_valid(rd_valid), .rd_bank(rd_bank),
    .bank_state(bank_state), .bank_open(bank_open)
`ifdef DDR_CMD_STATS_EN
    , .stat_act(stat_act), .stat_rd(stat_rd), .stat_wr(stat_wr), .stat_pr(stat_pr),
    .stat_ref(stat_ref), .stat_err(stat_err)
`endif
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: each bank knows its state, the unhalted edge index at which it
  // leaves that state and where it goes next; reads are a window of beat edge indices.
  int ms[NB], mexit[NB], mafter[NB];
  int ut, blo, bhi, bbank;
  logic e_err, e_rd;
  logic [1:0] e_rdb;
  longint mstat[6];

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin ms[i] = 0; mexit[i] = 0; mafter[i] = 0; end
    for (int i = 0; i < 6; i++) mstat[i] = 0;
    ut = 0; blo = -100; bhi = -100; bbank = 0;
    e_err = 1'b0; e_rd = 1'b0; e_rdb = 2'd0;
  endtask

  function automatic bit m_legal(input logic [3:0] c, input int b);
    bit busy = 0, blk = 0, idle = 1;
    for (int i = 0; i < NB; i++) begin
      if (ms[i] == 3 || ms[i] == 4) busy = 1;
      if (ms[i] == 1 || ms[i] == 3 || ms[i] == 4) blk = 1;
      if (ms[i] != 0) idle = 0;
    end
    case (c)
      CMD_NOP: return 1;
      CMD_ACT: return ms[b] == 0;
      CMD_RD, CMD_RDA, CMD_WR, CMD_WRA: return (ms[b] == 2) && !busy;
      CMD_PR: return (ms[b] == 2) || (ms[b] == 0);
      CMD_PRA: return !blk;
      CMD_REF: return idle;
      default: return 0;
    endcase
  endfunction

  task automatic model_edge(input logic h, input logic v, input logic [3:0] c, input logic [1:0] b);
    int t, bi;
    bit lg;
    int pre[NB];
    if (h) begin
      e_err = 1'b0;
    end else begin
      t = ut;
      bi = int'(b);
      lg = m_legal(c, bi);
      e_rd = (t >= blo) && (t <= bhi);
      e_rdb = 2'(bbank);
      pre = ms;
      for (int i = 0; i < NB; i++) begin
        if (pre[i] != 0 && pre[i] != 2 && mexit[i] == t) begin
          ms[i] = mafter[i];
          if (ms[i] == 5) begin mexit[i] = t + T_RP; mafter[i] = 0; end
        end
      end
      if (v && lg) begin
        case (c)
          CMD_ACT: begin ms[bi] = 1; mexit[bi] = t + T_RCD; mafter[bi] = 2; mstat[0]++; end
          CMD_RD, CMD_RDA: begin
            ms[bi] = 3; mexit[bi] = t + T_CL + T_BL; mafter[bi] = (c == CMD_RDA) ? 5 : 2;
            blo = t + T_CL + 1; bhi = t + T_CL + T_BL; bbank = bi; mstat[1]++;
          end
          CMD_WR, CMD_WRA: begin
            ms[bi] = 4; mexit[bi] = t + T_BL + T_WR; mafter[bi] = (c == CMD_WRA) ? 5 : 2;
            mstat[2]++;
          end
          CMD_PR: begin
            if (pre[bi] == 2) begin ms[bi] = 5; mexit[bi] = t + T_RP; mafter[bi] = 0; end
            mstat[3]++;
          end
          CMD_PRA: begin
            for (int i = 0; i < NB; i++)
              if (pre[i] == 2) begin ms[i] = 5; mexit[i] = t + T_RP; mafter[i] = 0; end
            mstat[3]++;
          end
          CMD_REF: begin
            for (int i = 0; i < NB; i++) begin ms[i] = 6; mexit[i] = t + T_RFC; mafter[i] = 0; end
            mstat[4]++;
          end
          default: ;
        endcase
      end
      if (v && !lg) mstat[5]++;
      e_err = v && !lg;
      ut++;
    end
  endtask

  task automatic compare_all();
    logic [11:0] es;
    logic [3:0] eo;
    for (int i = 0; i < NB; i++) begin
      es[i*3 +: 3] = 3'(ms[i]);
      eo[i] = (ms[i] == 2) || (ms[i] == 3) || (ms[i] == 4);
    end
    chk("bank_state", bank_state, es);
    chk("bank_open", bank_open, eo);
    chk("rd_valid", rd_valid, e_rd);
    if (e_rd) chk("rd_bank", rd_bank, e_rdb);
    chk("cmd_err", cmd_err, e_err);
`ifdef DDR_CMD_STATS_EN
    chk("stat_act", stat_act, mstat[0]);
    chk("stat_rd", stat_rd, mstat[1]);
    chk("stat_wr", stat_wr, mstat[2]);
    chk("stat_pr", stat_pr, mstat[3]);
    chk("stat_ref", stat_ref, mstat[4]);
    chk("stat_err", stat_err, mstat[5]);
`endif
  endtask

  task automatic step(input logic h, input logic v, input logic [3:0] c, input logic [1:0] b);
    halt = h; cmd_valid = v; cmd = c; cmd_bank = b;
    #1;
    chk("cmd_ready", cmd_ready, !h);
    @(posedge clk);
    model_edge(h, v, c, b);
    #1;
    compare_all();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, bank_state, 12'd0);
    chk({tag, "_open"}, bank_open, 4'd0);
    chk({tag, "_rd_valid"}, rd_valid, 1'b0);
    chk({tag, "_rd_bank"}, rd_bank, 2'd0);
    chk({tag, "_cmd_err"}, cmd_err, 1'b0);
`ifdef DDR_CMD_STATS_EN
    chk({tag, "_stats"}, stat_act | stat_rd | stat_wr | stat_pr | stat_ref | stat_err, 32'd0);
`endif
  endtask

  typedef struct {
    logic        v;
    logic [3:0]  c;
    logic [1:0]  b;
    logic        err;
    logic        rd;
    logic [11:0] st;
  } vec_t;
  vec_t vq[$];

  task automatic tv(input logic v, input logic [3:0] c, input logic [1:0] b, input logic err,
                    input logic rd, input logic [2:0] s3, input logic [2:0] s2,
                    input logic [2:0] s1, input logic [2:0] s0);
    vec_t e;
    e.v = v; e.c = c; e.b = b; e.err = err; e.rd = rd; e.st = {s3, s2, s1, s0};
    vq.push_back(e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, nb, r;
    logic [3:0] c;

    // directed table: expectations after each edge, banks listed b3,b2,b1,b0
    tv(1, CMD_ACT, 0, 0, 0, 0, 0, 0, 1);
    tv(1, CMD_ACT, 2, 0, 0, 0, 1, 0, 1);
    tv(1, CMD_NOP, 0, 0, 0, 0, 1, 0, 1);
    tv(1, CMD_NOP, 0, 0, 0, 0, 1, 0, 2);
    tv(1, CMD_RD,  1, 1, 0, 0, 2, 0, 2);
    tv(1, CMD_NOP, 0, 0, 0, 0, 2, 0, 2);
    tv(1, CMD_REF, 0, 1, 0, 0, 2, 0, 2);
    tv(1, CMD_NOP, 0, 0, 0, 0, 2, 0, 2);
    tv(1, CMD_RD,  0, 0, 0, 0, 2, 0, 3);
    tv(1, CMD_RD,  2, 1, 0, 0, 2, 0, 3);
    tv(1, CMD_WR,  2, 1, 0, 0, 2, 0, 3);
    tv(1, CMD_NOP, 0, 0, 0, 0, 2, 0, 3);
    tv(1, CMD_NOP, 0, 0, 0, 0, 2, 0, 3);
    for (int i = 0; i < 3; i++) tv(1, CMD_NOP, 0, 0, 1, 0, 2, 0, 3);
    tv(1, CMD_NOP, 0, 0, 1, 0, 2, 0, 2);
    tv(1, CMD_NOP, 0, 0, 0, 0, 2, 0, 2);
    for (int i = 0; i < 3; i++) tv(1, (i == 0) ? CMD_PRA : CMD_NOP, 0, 0, 0, 0, 5, 0, 5);
    tv(1, CMD_NOP, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) tv(1, (i == 0) ? CMD_REF : CMD_NOP, 0, 0, 0, 6, 6, 6, 6);
    tv(1, CMD_NOP, 0, 0, 0, 0, 0, 0, 0);
    tv(1, 4'hF,    0, 1, 0, 0, 0, 0, 0);
    tv(0, CMD_RD,  0, 0, 0, 0, 0, 0, 0);

    model_reset();
    #10;
    chk_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    foreach (vq[i]) begin
      step(1'b0, vq[i].v, vq[i].c, vq[i].b);
      chk("vec_err", cmd_err, vq[i].err);
      chk("vec_rd", rd_valid, vq[i].rd);
      if (vq[i].rd) chk("vec_rd_bank", rd_bank, 2'd0);
      chk("vec_state", bank_state, vq[i].st);
    end

    // halt for 3 cycles during ACTIVATING: ACTIVE arrives 3 cycles later
    step(1'b0, 1'b1, CMD_ACT, 2'd0);
    k = 0;
    for (int i = 0; i < 3; i++) begin step(1'b1, 1'b1, CMD_ACT, 2'd1); k++; end
    while (bank_state[2:0] != 3'd2 && k < 20) begin step(1'b0, 1'b0, CMD_NOP, 2'd0); k++; end
    chk("halt_act_stretch", k, 6);

    // halt for 4 cycles during READING: first beat arrives 4 cycles later
    step(1'b0, 1'b1, CMD_RD, 2'd0);
    k = 0;
    for (int i = 0; i < 2; i++) begin step(1'b0, 1'b0, CMD_NOP, 2'd0); k++; end
    for (int i = 0; i < 4; i++) begin step(1'b1, 1'b1, CMD_RD, 2'd1); k++; end
    while (!rd_valid && k < 30) begin step(1'b0, 1'b0, CMD_NOP, 2'd0); k++; end
    chk("halt_rd_latency", k, 9);
    nb = 0;
    while (rd_valid && nb < 30) begin nb++; step(1'b0, 1'b0, CMD_NOP, 2'd0); end
    chk("halt_rd_beats", nb, 4);
    chk("halt_rd_after", bank_state[2:0], 3'd2);

    // asynchronous reset in the middle of a burst
    step(1'b0, 1'b1, CMD_PRA, 2'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, CMD_NOP, 2'd0);
    step(1'b0, 1'b1, CMD_ACT, 2'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, CMD_NOP, 2'd0);
    step(1'b0, 1'b1, CMD_RD, 2'd1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, CMD_NOP, 2'd0);
    chk("pre_rst_burst", rd_valid, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    chk_reset_vals("mid_burst_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 25)      c = CMD_ACT;
      else if (r < 40) c = CMD_RD;
      else if (r < 48) c = CMD_RDA;
      else if (r < 58) c = CMD_WR;
      else if (r < 64) c = CMD_WRA;
      else if (r < 74) c = CMD_PR;
      else if (r < 78) c = CMD_PRA;
      else if (r < 81) c = CMD_REF;
      else if (r < 84) c = 4'(9 + $urandom_range(0, 6));
      else             c = CMD_NOP;
      step(($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 85), c, 2'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
